// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Control-side counterpart of the 6502 ALU. One accumulator-class opcode is
// accepted per start strobe (only while idle). For ALU ops it drives the
// one-hot operation select, carry-in and decimal enable for one EXEC cycle,
// then the SB output enable for one WB cycle, and then captures the ALU's
// returned flags into the status bits according to the op's update mask.
// Flag ops (CLC/SEC/CLD/SED/CLV) take a FLAG cycle and write one status bit.
// Opcodes this block does not handle are rejected with a one-cycle illegal
// pulse, and nothing else changes.
//
// Handshake: start is sampled, together with opcode, only on a rising edge in
// IDLE; a start arriving while busy is dropped, not queued. done pulses for
// the one cycle after completion, and a new start may be accepted in that
// cycle because the FSM is already back in IDLE.
//
// Ports:
//   clk, reset (async, active-low)
//   start, opcode[7:0]             request from the decode front end
//   cout, zero, overflow, neg      flags returned by the ALU
//   sums..shftcr                   one-hot ALU op selects (EXEC only)
//   cin, decEn, sboa               ALU carry in, BCD enable, result-to-SB
//   busy, done, illegal            status / completion pulses
//   c_flag..d_flag                 processor status bits
//   dbg_state[1:0]                 current FSM state (0 IDLE,1 EXEC,2 WB,3 FLAG)
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter bit         DEC_SUPPORT = 1'b1,
  parameter logic [4:0] P_RESET     = 5'b00000  // {n, v, d, z, c}
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       cout,
  input  logic       zero,
  input  logic       overflow,
  input  logic       neg,
  output logic       sums,
  output logic       subs,
  output logic       ands,
  output logic       eors,
  output logic       ors,
  output logic       shftr,
  output logic       shftcr,
  output logic       cin,
  output logic       decEn,
  output logic       sboa,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       c_flag,
  output logic       z_flag,
  output logic       v_flag,
  output logic       n_flag,
  output logic       d_flag,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2,
    S_FLAG = 2'd3
  } state_t;

  // Which status bit a flag op writes.
  localparam logic [1:0] F_C = 2'd0;
  localparam logic [1:0] F_D = 2'd1;
  localparam logic [1:0] F_V = 2'd2;

  // Select vector order: {sums, subs, ands, eors, ors, shftr, shftcr}
  localparam logic [6:0] SEL_SUM  = 7'b1000000;
  localparam logic [6:0] SEL_SUB  = 7'b0100000;
  localparam logic [6:0] SEL_AND  = 7'b0010000;
  localparam logic [6:0] SEL_EOR  = 7'b0001000;
  localparam logic [6:0] SEL_OR   = 7'b0000100;
  localparam logic [6:0] SEL_SHR  = 7'b0000010;
  localparam logic [6:0] SEL_SHCR = 7'b0000001;

  // Update mask order: {N, Z, C, V}
  localparam logic [3:0] M_NZ   = 4'b1100;
  localparam logic [3:0] M_NZC  = 4'b1110;
  localparam logic [3:0] M_NZCV = 4'b1111;

  state_t     state;
  logic [6:0] sel_q;
  logic [3:0] mask_q;
  logic [1:0] fsel_q;
  logic       fval_q;

  // Decode results for the opcode currently presented.
  logic       d_alu;
  logic       d_flagop;
  logic [6:0] d_sel;
  logic       d_cin;
  logic       d_dec;
  logic       d_wb;
  logic [3:0] d_mask;
  logic [1:0] d_fsel;
  logic       d_fval;

  // Decimal mode only reaches the ALU when BCD is built in.
  logic       dec_mode;
  assign dec_mode = d_flag & DEC_SUPPORT;

  always_comb begin
    d_alu    = 1'b0;
    d_flagop = 1'b0;
    d_sel    = 7'b0;
    d_cin    = 1'b0;
    d_dec    = 1'b0;
    d_wb     = 1'b1;
    d_mask   = 4'b0;
    d_fsel   = F_C;
    d_fval   = 1'b0;
    case (opcode)
      8'h4A: begin d_alu = 1'b1; d_sel = SEL_SHR;  d_cin = 1'b0;   d_mask = M_NZC; end
      8'h6A: begin d_alu = 1'b1; d_sel = SEL_SHCR; d_cin = c_flag; d_mask = M_NZC; end
      8'h18: begin d_flagop = 1'b1; d_fsel = F_C; d_fval = 1'b0; end
      8'h38: begin d_flagop = 1'b1; d_fsel = F_C; d_fval = 1'b1; end
      8'hD8: begin d_flagop = 1'b1; d_fsel = F_D; d_fval = 1'b0; end
      8'hF8: begin d_flagop = 1'b1; d_fsel = F_D; d_fval = 1'b1; end
      8'hB8: begin d_flagop = 1'b1; d_fsel = F_V; d_fval = 1'b0; end
      default: begin
        // ALU group: cc=01, operation in aaa, addressing mode ignored here.
        if (opcode[1:0] == 2'b01) begin
          case (opcode[7:5])
            3'b000: begin d_alu = 1'b1; d_sel = SEL_OR;  d_mask = M_NZ; end
            3'b001: begin d_alu = 1'b1; d_sel = SEL_AND; d_mask = M_NZ; end
            3'b010: begin d_alu = 1'b1; d_sel = SEL_EOR; d_mask = M_NZ; end
            3'b011: begin
              d_alu = 1'b1; d_sel = SEL_SUM; d_cin = c_flag; d_dec = dec_mode;
              d_mask = M_NZCV;
            end
            3'b110: begin
              // CMP: subtract with no borrow, result not written back.
              d_alu = 1'b1; d_sel = SEL_SUB; d_cin = 1'b1; d_wb = 1'b0;
              d_mask = M_NZC;
            end
            3'b111: begin
              d_alu = 1'b1; d_sel = SEL_SUB; d_cin = c_flag; d_dec = dec_mode;
              d_mask = M_NZCV;
            end
            default: ;  // 100 (STA) and 101 (LDA) are not ALU work
          endcase
        end
      end
    endcase
  end

  logic wb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      sel_q   <= 7'b0;
      cin     <= 1'b0;
      decEn   <= 1'b0;
      sboa    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      mask_q  <= 4'b0;
      wb_q    <= 1'b0;
      fsel_q  <= F_C;
      fval_q  <= 1'b0;
      {n_flag, v_flag, d_flag, z_flag, c_flag} <= P_RESET;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (d_alu) begin
              state  <= S_EXEC;
              sel_q  <= d_sel;
              cin    <= d_cin;
              decEn  <= d_dec;
              mask_q <= d_mask;
              wb_q   <= d_wb;
              busy   <= 1'b1;
            end else if (d_flagop) begin
              state  <= S_FLAG;
              fsel_q <= d_fsel;
              fval_q <= d_fval;
              busy   <= 1'b1;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          state <= S_WB;
          sel_q <= 7'b0;
          cin   <= 1'b0;
          decEn <= 1'b0;
          sboa  <= wb_q;
        end
        S_WB: begin
          state <= S_IDLE;
          sboa  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (mask_q[3]) n_flag <= neg;
          if (mask_q[2]) z_flag <= zero;
          if (mask_q[1]) c_flag <= cout;
          if (mask_q[0]) v_flag <= overflow;
        end
        S_FLAG: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          case (fsel_q)
            F_C:     c_flag <= fval_q;
            F_D:     d_flag <= fval_q;
            default: v_flag <= fval_q;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {sums, subs, ands, eors, ors, shftr, shftcr} = sel_q;
  assign dbg_state = state;

endmodule
